nn_frame_streamer: RTL and testbench
====================================

// Module: nn_frame_streamer
// PURPOSE
// - Upstream feeder of the digit-classifier core: buffers one 28x28 grayscale frame of 8-bit pixels,
//   converts each pixel to signed fixed point, streams the frame into the core, then captures its prediction.
// - Owns the core's enable and clear, so the core's address counter and MAC accumulators start each frame from zero.
// - Sits between the pixel source (UART/camera front end) and the classifier.
// PARAMETERS
// - WGHT_INT    6    integer bits of the core's fixed-point word
// - WGHT_FRC    16   fractional bits; must equal 2*PIX_W (elaboration-time assertion)
// - PIX_W       8    input pixel width
// - WIDTH       784  pixels per frame
// - RESULT_LAT  4    cycles from the last nn_en high to the cycle nn_result is sampled
// PORTS
// - clk         in   1              clock
// - reset       in   1              asynchronous, active-high reset
// - in_valid    in   1              pixel source has data
// - in_ready    out  1              block accepts a pixel (transfer = in_valid & in_ready)
// - in_sof      in   1              start of frame, qualified by the transfer
// - in_pix      in   PIX_W          unsigned pixel, 0 = black
// - nn_clr      out  1              one-cycle clear to the core (OR'd with reset at the core)
// - nn_en       out  1              core enable; high for exactly WIDTH consecutive cycles per frame
// - nn_din      out  WGHT_INT+WGHT_FRC  pixel in fixed point, valid while nn_en is high
// - nn_result   in   WGHT_INT+WGHT_FRC  predicted digit from the core
// - result      out  4              captured digit, nn_result[3:0]
// - result_valid out 1              one-cycle pulse when result updates
// - busy        out  1              high from end of frame load until result_valid
// BEHAVIOUR
// - Reset (async): state LOAD, wr_addr=0, rd_addr=0. Outputs: in_ready=1, nn_clr=0, nn_en=0, nn_din=0,
//   result=0, result_valid=0, busy=0.
// - FSM: LOAD -> CLR -> RUN -> WAIT -> DONE -> LOAD.
// - LOAD: in_ready=1.
//   - Each transfer writes buf[wr_addr]=in_pix, then wr_addr++.
//   - A transfer with in_sof=1 writes address 0 and sets wr_addr=1, restarting the frame even mid-frame.
//   - The transfer at wr_addr==WIDTH-1 moves the FSM to CLR. in_ready drops in the following cycle.
// - CLR: nn_clr=1 for exactly one cycle; rd_addr=0; busy=1.
// - RUN: buffer read is synchronous; nn_en and nn_din are registered and aligned.
//   - Pixel k appears on nn_din in the k-th cycle of a WIDTH-cycle nn_en burst, k=0..WIDTH-1, no gaps.
//   - The first nn_en cycle is two cycles after the CLR cycle (one read stage, one output register).
// - WAIT: a counter runs RESULT_LAT cycles starting after the last nn_en-high cycle. On expiry the FSM
//   samples nn_result into result.
// - DONE: result_valid=1 for one cycle, busy=0. The next cycle is LOAD with in_ready=1 and wr_addr=0.
// - Conversion: nn_din = {WGHT_INT'b0, in_pix, in_pix}.
//   - This equals pix*257/65536, about pix/255. 0x00 -> 0.0, 0xFF -> 0x00FFFF (~1.0).
//   - Always non-negative.
// - in_ready=0 in CLR/RUN/WAIT/DONE. in_valid is ignored there, with no write and no error.
// - in_sof is ignored when in_valid=0 or in_ready=0.
// - Reset asserted mid-RUN/WAIT: nn_en falls asynchronously to 0. The partial frame is discarded and
//   result keeps its reset value 0.
// - WIDTH addressing: wr_addr and rd_addr are $clog2(WIDTH) bits. Neither counter ever wraps past WIDTH-1.
// STRUCTURE
// - Package nn_pkg:
//   - WGHT_INT, WGHT_FRC, WIDTH, PIX_W defaults
//   - typedef fx_t logic [WGHT_INT+WGHT_FRC-1:0]
//   - typedef enum state_t {LOAD, CLR, RUN, WAIT, DONE}
//   - function pix2fx
// - Sub-module frame_buf_ram: simple dual-port RAM, WIDTH x PIX_W, one write port, one synchronous
//   read port (1-cycle latency), no reset on contents.
// - Top holds the FSM, address counters, latency counter and output registers.
// TESTING
// - Frame of 784 x 0xFF -> one nn_clr pulse, then exactly 784 cycles nn_en=1 with nn_din=22'h00FFFF each, then nn_en=0.
// - Ramp frame pix[k]=k%256 -> nn_din in burst cycle k equals {6'b0, k%256, k%256}; check all 784.
// - in_valid held high through RUN/WAIT -> in_ready=0 there, no buffer write; the next frame loads intact.
// - in_sof re-asserted at pixel 100 -> burst starts only after 784 further transfers; data comes from the new frame.
// - Stub core drives nn_result=7 -> result=7 and result_valid high for one cycle, RESULT_LAT+1 cycles after the last nn_en.
// - reset pulsed at burst cycle 300 -> nn_en=0 immediately; after release in_ready=1, busy=0, result=0, no result_valid.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and defaults for the frame streamer that feeds the digit-classifier core.
// pix2fx maps an 8-bit pixel onto the core's unsigned Q6.16 word.
package nn_pkg;
    localparam int DEF_WGHT_INT   = 6;
    localparam int DEF_WGHT_FRC   = 16;
    localparam int DEF_PIX_W      = 8;
    localparam int DEF_WIDTH      = 784;
    localparam int DEF_RESULT_LAT = 4;

    typedef logic [DEF_WGHT_INT+DEF_WGHT_FRC-1:0] fx_t;

    typedef enum logic [2:0] {LOAD, CLR, RUN, WAIT, DONE} state_t;

    // Repeating the byte gives pix*257/65536, which puts 0xFF just below 1.0.
    function automatic fx_t pix2fx(input logic [DEF_PIX_W-1:0] pix);
        return {{DEF_WGHT_INT{1'b0}}, pix, pix};
    endfunction
endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Contents are not reset; every frame overwrites all locations before they are read.
module frame_buf_ram #(
    parameter int DEPTH = 784,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/nn_frame_streamer.sv
// Buffers one frame of pixels, streams it into the classifier core as fixed point,
// then captures the core's prediction.
module nn_frame_streamer
    import nn_pkg::*;
#(
    parameter int WGHT_INT   = DEF_WGHT_INT,
    parameter int WGHT_FRC   = DEF_WGHT_FRC,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RESULT_LAT = DEF_RESULT_LAT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [PIX_W-1:0]             in_pix,
    output logic                         nn_clr,
    output logic                         nn_en,
    output logic [WGHT_INT+WGHT_FRC-1:0] nn_din,
    input  logic [WGHT_INT+WGHT_FRC-1:0] nn_result,
    output logic [3:0]                   result,
    output logic                         result_valid,
    output logic                         busy,
    output state_t                       state
);
    localparam int FX_W = WGHT_INT + WGHT_FRC;
    localparam int AW   = $clog2(WIDTH);
    localparam int CW   = $clog2(RESULT_LAT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(RESULT_LAT - 1);

    generate
        if (WGHT_FRC != 2 * PIX_W || FX_W != $bits(fx_t) || PIX_W != DEF_PIX_W) begin : g_bad_format
            $error("nn_frame_streamer: fixed-point format must be Q%0d.%0d with WGHT_FRC == 2*PIX_W",
                   DEF_WGHT_INT, DEF_WGHT_FRC);
        end
    endgenerate

    state_t          state_q, state_d;
    logic            load_xfer;
    logic [AW-1:0]   wr_addr, rd_addr, waddr;
    logic [CW-1:0]   lat_cnt;
    logic            rd_vld;
    logic [PIX_W-1:0] rd_pix;
    logic            unused_result_hi;

    assign state            = state_q;
    assign load_xfer        = in_valid && (state_q == LOAD);
    assign waddr            = in_sof ? '0 : wr_addr;
    assign unused_result_hi = ^nn_result[FX_W-1:4];

    // Handshake: a pixel moves on a cycle where in_valid and in_ready are both high;
    // in_sof and in_pix are only meaningful on such a cycle.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        nn_clr       = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (load_xfer && !in_sof && wr_addr == LAST_ADDR) state_d = CLR;
            end
            CLR: begin
                nn_clr  = 1'b1;
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (rd_addr == LAST_ADDR) state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (!nn_en && lat_cnt == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_d      = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOAD;
        else       state_q <= state_d;
    end

    // An sof transfer lands at address 0 and restarts the frame from there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
        end else if (load_xfer) begin
            if (in_sof)                    wr_addr <= AW'(1);
            else if (wr_addr == LAST_ADDR) wr_addr <= '0;
            else                           wr_addr <= wr_addr + 1'b1;
        end
    end

    // Address 0 is issued during CLR so the first pixel reaches nn_din two cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            rd_vld  <= 1'b0;
            nn_en   <= 1'b0;
            nn_din  <= '0;
        end else begin
            if (state_q == WAIT)
                rd_addr <= '0;
            else if ((state_q == CLR || state_q == RUN) && rd_addr != LAST_ADDR)
                rd_addr <= rd_addr + 1'b1;
            rd_vld <= (state_q == CLR || state_q == RUN);
            nn_en  <= rd_vld;
            nn_din <= rd_vld ? pix2fx(rd_pix) : '0;
        end
    end

    // The latency count only starts once the last enabled cycle has left nn_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
            result  <= '0;
        end else begin
            if (state_q == WAIT && !nn_en)
                lat_cnt <= (lat_cnt == LAST_CNT) ? '0 : lat_cnt + 1'b1;
            if (state_q == WAIT && state_d == DONE)
                result <= nn_result[3:0];
        end
    end

    frame_buf_ram #(
        .DEPTH (WIDTH),
        .DW    (PIX_W),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (load_xfer),
        .waddr (waddr),
        .wdata (in_pix),
        .raddr (rd_addr),
        .rdata (rd_pix)
    );
endmodule

// File: tb/tb_nn_frame_streamer.sv
// Directed bench for nn_frame_streamer: loads frames, checks the nn_en burst cycle by cycle,
// the result capture timing, mid-frame sof restart and reset during a burst.
module tb_nn_frame_streamer;
    import nn_pkg::*;

    localparam int WIDTH = 784;
    localparam int FX_W  = 22;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sof = 1'b0;
    logic [7:0]      in_pix = '0;
    logic            nn_clr;
    logic            nn_en;
    logic [FX_W-1:0] nn_din;
    logic [FX_W-1:0] nn_result = '0;
    logic [3:0]      result;
    logic            result_valid;
    logic            busy;
    state_t          state;

    int errors = 0;
    int checks = 0;
    logic [7:0] frame [WIDTH];

    always #5 clk = ~clk;

    nn_frame_streamer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_pix       (in_pix),
        .nn_clr       (nn_clr),
        .nn_en        (nn_en),
        .nn_din       (nn_din),
        .nn_result    (nn_result),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .state        (state)
    );

    // Drives one full frame; in_valid stays high after the last pixel until the caller changes it.
    task automatic load_frame(input logic with_sof);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready pix=%0d in_ready=%b expected 1", k, in_ready);
            end
            in_valid = 1'b1;
            in_sof   = with_sof && (k == 0);
            in_pix   = frame[k];
        end
    endtask

    task automatic check_frame(input logic hold, input logic [3:0] exp_res);
        logic [FX_W-1:0] exp_din;
        @(negedge clk);
        if (hold) begin
            in_pix = 8'h5A;
            in_sof = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        checks++;
        if ({nn_clr, busy, in_ready, nn_en} !== 4'b1100 || state !== CLR) begin
            errors++;
            $display("FAIL clr_cycle clr/busy/ready/en=%b state=%0d expected 1100 state=%0d",
                     {nn_clr, busy, in_ready, nn_en}, state, CLR);
        end
        @(negedge clk);
        checks++;
        if ({nn_clr, nn_en} !== 2'b00) begin
            errors++;
            $display("FAIL pre_burst clr/en=%b expected 00", {nn_clr, nn_en});
        end
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            exp_din = {6'b0, frame[k], frame[k]};
            checks++;
            if (nn_en !== 1'b1 || nn_din !== exp_din) begin
                errors++;
                $display("FAIL burst k=%0d en=%b din=%h expected en=1 din=%h", k, nn_en, nn_din, exp_din);
            end
            if (hold) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_run k=%0d in_ready=%b expected 0", k, in_ready);
                end
                if (k == 400) in_sof = 1'b1;
            end
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({nn_en, result_valid, busy, in_ready} !== 4'b0010) begin
                errors++;
                $display("FAIL wait_cycle %0d en/rv/busy/ready=%b expected 0010",
                         i, {nn_en, result_valid, busy, in_ready});
            end
        end
        @(negedge clk);
        checks++;
        if ({result_valid, busy, in_ready} !== 3'b100 || result !== exp_res) begin
            errors++;
            $display("FAIL done_cycle rv/busy/ready=%b result=%0d expected 100 result=%0d",
                     {result_valid, busy, in_ready}, result, exp_res);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
        checks++;
        if ({result_valid, in_ready} !== 2'b01 || result !== exp_res || state !== LOAD) begin
            errors++;
            $display("FAIL after_done rv/ready=%b result=%0d state=%0d expected 01 result=%0d state=%0d",
                     {result_valid, in_ready}, result, state, exp_res, LOAD);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, nn_clr, nn_en, busy, result_valid} !== 5'b10000 || nn_din !== '0
            || result !== 4'd0 || state !== LOAD) begin
            errors++;
            $display("FAIL reset_hold ready/clr/en/busy/rv=%b din=%h result=%0d expected 10000 0 0",
                     {in_ready, nn_clr, nn_en, busy, result_valid}, nn_din, result);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, nn_clr, nn_en, busy, result_valid} !== 5'b10000 || result !== 4'd0) begin
            errors++;
            $display("FAIL reset_release ready/clr/en/busy/rv=%b result=%0d expected 10000 0",
                     {in_ready, nn_clr, nn_en, busy, result_valid}, result);
        end
    endtask

    task automatic test_all_ff();
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'hFF;
        nn_result = 22'd7;
        load_frame(1'b1);
        check_frame(1'b0, 4'd7);
    endtask

    task automatic test_ramp();
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'(k % 256);
        nn_result = 22'h2ABCD3;
        load_frame(1'b1);
        check_frame(1'b0, 4'd3);
    endtask

    task automatic test_hold_valid();
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'((k * 7 + 3) % 256);
        nn_result = 22'd9;
        load_frame(1'b1);
        check_frame(1'b1, 4'd9);
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'(255 - (k % 256));
        nn_result = 22'd5;
        load_frame(1'b0);
        check_frame(1'b0, 4'd5);
    endtask

    task automatic test_sof_restart();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL partial_ready pix=%0d in_ready=%b expected 1", k, in_ready);
            end
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_pix   = 8'hEE;
        end
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'((k * 13) % 256);
        nn_result = 22'd2;
        load_frame(1'b1);
        check_frame(1'b0, 4'd2);
    endtask

    task automatic test_reset_mid_burst();
        logic [FX_W-1:0] exp_din;
        for (int k = 0; k < WIDTH; k++) frame[k] = 8'(k % 256) ^ 8'h3C;
        nn_result = 22'd6;
        load_frame(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        repeat (301) @(negedge clk);
        exp_din = {6'b0, frame[300], frame[300]};
        checks++;
        if (nn_en !== 1'b1 || nn_din !== exp_din) begin
            errors++;
            $display("FAIL burst_300 en=%b din=%h expected en=1 din=%h", nn_en, nn_din, exp_din);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({nn_en, busy, in_ready} !== 3'b001 || nn_din !== '0 || result !== 4'd0) begin
            errors++;
            $display("FAIL async_reset en/busy/ready=%b din=%h result=%0d expected 001 0 0",
                     {nn_en, busy, in_ready}, nn_din, result);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({nn_en, result_valid, busy, in_ready, nn_clr} !== 5'b00010 || result !== 4'd0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d en/rv/busy/ready/clr=%b result=%0d expected 00010 0",
                         i, {nn_en, result_valid, busy, in_ready, nn_clr}, result);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ff();
        test_ramp();
        test_hold_valid();
        test_sof_restart();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
